// File: rtl/ma_pkg.sv
// Shared types and default constants for the multiply-add accumulator slice.
package ma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } ma_state_e;

    localparam int unsigned MA_IN_W   = 5;
    localparam int unsigned MA_ACC_W  = 8;
    localparam int unsigned MA_N      = 8;
    localparam int unsigned MA_CNT_W  = 8;

endpackage

// File: rtl/ma_accum_if.sv
// Product input and result output handshakes of ma_accum, plus abort and status.
interface ma_accum_if import ma_pkg::*; #(
    parameter int unsigned IN_W  = MA_IN_W,
    parameter int unsigned ACC_W = MA_ACC_W
);

    logic [IN_W-1:0]     p_in;
    logic                p_valid;
    logic                p_ready;
    logic                clr;
    logic [ACC_W-1:0]    acc_out;
    logic                acc_valid;
    logic                acc_ready;
    logic                ovf;
    logic [MA_CNT_W-1:0] cnt;

    // Producer/sink side.
    modport master (
        output p_in,
        output p_valid,
        output clr,
        output acc_ready,
        input  p_ready,
        input  acc_out,
        input  acc_valid,
        input  ovf,
        input  cnt
    );

    // Accumulator side.
    modport slave (
        input  p_in,
        input  p_valid,
        input  clr,
        input  acc_ready,
        output p_ready,
        output acc_out,
        output acc_valid,
        output ovf,
        output cnt
    );

endinterface

// File: rtl/ma_blk_cnt.sv
// Counts accepted products within a block; flags the accept that completes it.
module ma_blk_cnt import ma_pkg::*; (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    input  logic [MA_CNT_W-1:0] n,
    output logic [MA_CNT_W-1:0] cnt,
    output logic                last
);

    logic [MA_CNT_W-1:0] cnt_q, cnt_d;

    assign last = inc && (cnt_q == (n - MA_CNT_W'(1)));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            // The completing accept wraps straight back to an empty block.
            cnt_d = last ? '0 : cnt_q + MA_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ma_accum.sv
// Sums blocks of N products and holds each sum for a valid/ready sink.
// Define MA_ACC_SAT_EN to saturate on overflow instead of wrapping.
module ma_accum import ma_pkg::*; #(
    parameter int unsigned N     = MA_N,
    parameter int unsigned IN_W  = MA_IN_W,
    parameter int unsigned ACC_W = MA_ACC_W
) (
    input logic        clk,
    input logic        rst,
    ma_accum_if.slave  bus
);

    localparam int unsigned        SumW = ACC_W + 1;
    localparam logic [MA_CNT_W-1:0] NCnt = MA_CNT_W'(N);

    ma_state_e         state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic              ovf_run_q, ovf_run_d;
    logic              acc_valid_q, acc_valid_d;
    logic              ovf_q, ovf_d;

    logic              p_ready;
    logic              accept;
    logic              blk_clr;
    logic              last;
    logic [MA_CNT_W-1:0] cnt;
    logic [SumW-1:0]   sum;
    logic [ACC_W-1:0]  acc_next;
    logic              ovf_next;

    assign p_ready  = (state_q != HOLD);
    // clr beats a simultaneous product; in HOLD it is ignored so the result survives.
    assign blk_clr  = bus.clr && (state_q != HOLD);
    assign accept   = bus.p_valid && p_ready && !bus.clr;

    assign sum      = SumW'(acc_q) + SumW'(bus.p_in);
    assign ovf_next = ovf_run_q | sum[ACC_W];

`ifdef MA_ACC_SAT_EN
    assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    ma_blk_cnt u_blk_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .clr  (blk_clr),
        .n    (NCnt),
        .cnt  (cnt),
        .last (last)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_run_d   = ovf_run_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            IDLE, ACCUM: begin
                if (blk_clr) begin
                    state_d   = IDLE;
                    acc_d     = '0;
                    ovf_run_d = 1'b0;
                end else if (accept) begin
                    if (last) begin
                        state_d     = HOLD;
                        acc_d       = '0;
                        ovf_run_d   = 1'b0;
                        acc_out_d   = acc_next;
                        acc_valid_d = 1'b1;
                        ovf_d       = ovf_next;
                    end else begin
                        state_d   = ACCUM;
                        acc_d     = acc_next;
                        ovf_run_d = ovf_next;
                    end
                end
            end
            HOLD: begin
                if (bus.acc_ready) begin
                    state_d     = IDLE;
                    acc_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_run_q   <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_run_q   <= ovf_run_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.p_ready   = p_ready;
    assign bus.acc_out   = acc_out_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.cnt       = cnt;

endmodule

// File: tb/tb_ma_accum.sv
// Self-checking bench for ma_accum: an 8-bit and a 7-bit instance share one stimulus stream.
module tb_ma_accum;
    import ma_pkg::*;

    localparam int unsigned N    = 8;
    localparam int unsigned IN_W = 5;
`ifdef MA_ACC_SAT_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ma_accum_if #(.IN_W(IN_W), .ACC_W(8)) bus  ();
    ma_accum_if #(.IN_W(IN_W), .ACC_W(7)) bus7 ();

    assign bus7.p_in      = bus.p_in;
    assign bus7.p_valid   = bus.p_valid;
    assign bus7.clr       = bus.clr;
    assign bus7.acc_ready = bus.acc_ready;

    ma_accum #(.N(N), .IN_W(IN_W), .ACC_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ma_accum #(.N(N), .IN_W(IN_W), .ACC_W(7)) dut7 (
        .clk (clk),
        .rst (rst),
        .bus (bus7.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Final block sum as seen by a w-bit accumulator.
    function automatic int fold(input int total, input int w, output bit o);
        int mx;
        mx = (1 << w) - 1;
        o  = (total > mx);
        if (!o) return total;
        return Sat ? mx : (total % (mx + 1));
    endfunction

    // Model: accepted products of the open block, and the held result.
    int q[$];
    bit m_hold = 1'b0;
    int m_out8 = 0;
    int m_out7 = 0;
    bit m_ovf8 = 1'b0;
    bit m_ovf7 = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_hold = 1'b0;
                m_out8 = 0;
                m_out7 = 0;
                m_ovf8 = 1'b0;
                m_ovf7 = 1'b0;
            end else if (m_hold) begin
                if (bus.acc_ready) m_hold = 1'b0;
            end else if (bus.clr) begin
                q.delete();
            end else if (bus.p_valid) begin
                q.push_back(int'(bus.p_in));
                if (q.size() == N) begin
                    int total;
                    total = 0;
                    foreach (q[i]) total += q[i];
                    m_out8 = fold(total, 8, m_ovf8);
                    m_out7 = fold(total, 7, m_ovf7);
                    m_hold = 1'b1;
                    q.delete();
                end
            end
            #1;
            chk("p_ready",    int'(bus.p_ready),    int'(!m_hold));
            chk("acc_valid",  int'(bus.acc_valid),  int'(m_hold));
            chk("cnt",        int'(bus.cnt),        q.size());
            chk("acc_valid7", int'(bus7.acc_valid), int'(m_hold));
            chk("cnt7",       int'(bus7.cnt),       q.size());
            if (m_hold) begin
                chk("acc_out",  int'(bus.acc_out),  m_out8);
                chk("ovf",      int'(bus.ovf),      int'(m_ovf8));
                chk("acc_out7", int'(bus7.acc_out), m_out7);
                chk("ovf7",     int'(bus7.ovf),     int'(m_ovf7));
            end
        end
    end

    task automatic drive(input logic v, input int d);
        @(negedge clk);
        bus.p_valid = v;
        bus.p_in    = IN_W'(d);
    endtask

    initial begin
        bus.p_in      = '0;
        bus.p_valid   = 1'b0;
        bus.clr       = 1'b0;
        bus.acc_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_p_ready",   int'(bus.p_ready),   1);
        chk("rst_acc_valid", int'(bus.acc_valid), 0);
        chk("rst_acc_out",   int'(bus.acc_out),   0);
        chk("rst_ovf",       int'(bus.ovf),       0);
        chk("rst_cnt",       int'(bus.cnt),       0);

        // 8 x 4 with the sink ready.
        for (int i = 0; i < 8; i++) drive(1'b1, 4);
        drive(1'b0, 0);
        chk("t1_valid",   int'(bus.acc_valid), 1);
        chk("t1_out",     int'(bus.acc_out),   32);
        chk("t1_ovf",     int'(bus.ovf),       0);
        chk("t1_cnt",     int'(bus.cnt),       0);
        chk("t1_ready_0", int'(bus.p_ready),   0);
        drive(1'b0, 0);
        chk("t1_ready_1", int'(bus.p_ready),   1);

        // Products 1..8 with idle gaps between them.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i);
            drive(1'b0, 0);
            if (i < 8) chk("t2_gap_cnt", int'(bus.cnt), i);
        end
        chk("t2_out", int'(bus.acc_out), 36);
        drive(1'b0, 0);

        // Sink stalls while the source keeps offering; clr in HOLD must not lose the result.
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(1'b1, 2);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 9);
            bus.clr = (k == 2);
            chk("t3_ready", int'(bus.p_ready),   0);
            chk("t3_valid", int'(bus.acc_valid), 1);
            chk("t3_out",   int'(bus.acc_out),   16);
        end
        drive(1'b1, 9);
        bus.clr       = 1'b0;
        bus.acc_ready = 1'b1;
        chk("t3_hold_last", int'(bus.acc_valid), 1);
        drive(1'b1, 9);
        chk("t3_delivered", int'(bus.acc_valid), 0);
        chk("t3_not_taken", int'(bus.cnt),       0);
        drive(1'b1, 1);
        chk("t3_retry_taken", int'(bus.cnt), 1);

        // clr with a simultaneous product after 3 accepts.
        drive(1'b1, 1);
        drive(1'b1, 7);
        bus.clr = 1'b1;
        chk("t4_cnt_before", int'(bus.cnt), 3);
        drive(1'b0, 0);
        bus.clr = 1'b0;
        chk("t4_cnt",   int'(bus.cnt),       0);
        chk("t4_valid", int'(bus.acc_valid), 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 3);
        drive(1'b0, 0);
        chk("t4_out",  int'(bus.acc_out),  24);
        chk("t4_out7", int'(bus7.acc_out), 24);
        drive(1'b0, 0);

        // 8 x 31: fits 8 bits, overflows 7 bits.
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(1'b1, 31);
        drive(1'b0, 0);
        chk("t5_out8",  int'(bus.acc_out),  248);
        chk("t5_ovf8",  int'(bus.ovf),      0);
        chk("t5_out7",  int'(bus7.acc_out), Sat ? 127 : 120);
        chk("t5_ovf7",  int'(bus7.ovf),     1);

        // Reset while holding a result.
        drive(1'b0, 0);
        rst = 1'b1;
        chk("t6_pre_valid", int'(bus.acc_valid), 1);
        drive(1'b0, 0);
        rst = 1'b0;
        chk("t6_valid",  int'(bus.acc_valid),  0);
        chk("t6_out",    int'(bus.acc_out),    0);
        chk("t6_ovf",    int'(bus.ovf),        0);
        chk("t6_ready",  int'(bus.p_ready),    1);
        chk("t6_ovf7",   int'(bus7.ovf),       0);
        chk("t6_out7",   int'(bus7.acc_out),   0);

        // Reset mid-block, then a clean block.
        bus.acc_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 5);
        drive(1'b0, 0);
        rst = 1'b1;
        drive(1'b0, 0);
        rst = 1'b0;
        chk("t6_mid_cnt", int'(bus.cnt), 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1);
        drive(1'b0, 0);
        chk("t6_after_out", int'(bus.acc_out), 8);
        repeat (3) drive(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
